// File: rtl/pwm_gen_core_if.sv
// pwm_gen_core_if: PWM control/status bundle; master drives configuration, slave returns counter, pulses and pins
interface pwm_gen_core_if #(
  parameter int CNT_W   = 32,
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 8
);
  logic                    enable;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [NUM_CH-1:0]       polarity;
  logic [PRESC_W-1:0]      prescale;
  logic                    update_req;
  logic                    update_ack;
  logic                    period_end;
  logic [CNT_W-1:0]        counter;
  logic [NUM_CH-1:0]       pwm_out;
  modport master (
    output enable, period, duty, polarity, prescale, update_req,
    input  update_ack, period_end, counter, pwm_out
  );
  modport slave (
    input  enable, period, duty, polarity, prescale, update_req,
    output update_ack, period_end, counter, pwm_out
  );
endinterface

// File: rtl/pwm_gen_core.sv
// pwm_gen_core: multi-channel PWM with double-buffered period/duty/polarity/prescale applied on period boundaries; ports ACLK, ARESET (sync active-high), bus (slave)
module pwm_gen_core #(
  parameter int CNT_W   = 32,
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 8
) (
  input logic           ACLK,
  input logic           ARESET,
  pwm_gen_core_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                  state;
  logic [CNT_W-1:0]        per_sh, cnt;
  logic [NUM_CH*CNT_W-1:0] duty_sh;
  logic [NUM_CH-1:0]       pol_sh, raw, pwm;
  logic [PRESC_W-1:0]      presc_sh, presc;
  logic                    pending, ack, pe;
  logic                    tick, wrap, want, take, load;
  always_comb begin
    tick = presc == presc_sh;
    wrap = state == RUN && bus.enable && tick && cnt == per_sh;
    want = pending | bus.update_req;
    take = want && (state == IDLE || wrap);
    load = take || (state == IDLE && bus.enable);
    raw  = '0;
    for (int i = 0; i < NUM_CH; i++) raw[i] = cnt < duty_sh[i*CNT_W +: CNT_W];
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      per_sh   <= '0;
      duty_sh  <= '0;
      pol_sh   <= '0;
      presc_sh <= '0;
      cnt      <= '0;
      presc    <= '0;
      pending  <= 1'b0;
      pwm      <= '0;
      ack      <= 1'b0;
      pe       <= 1'b0;
    end else begin
      if (load) begin
        per_sh   <= bus.period;
        duty_sh  <= bus.duty;
        pol_sh   <= bus.polarity;
        presc_sh <= bus.prescale;
      end
      ack     <= take;
      pe      <= wrap;
      pending <= want & ~take;
      if (state == RUN && bus.enable) begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        cnt   <= tick ? (wrap ? '0 : cnt + CNT_W'(1)) : cnt;
        pwm   <= raw ^ pol_sh;
      end else begin
        state <= bus.enable ? RUN : IDLE;
        presc <= '0;
        cnt   <= '0;
        pwm   <= pol_sh;
      end
    end
  end
  assign bus.update_ack = ack;
  assign bus.period_end = pe;
  assign bus.counter    = cnt;
  assign bus.pwm_out    = pwm;
endmodule

// File: tb/tb_pwm_gen_core.sv
// tb_pwm_gen_core: table-driven and scoreboard checks of pwm_gen_core waveforms, update timing, enable and reset
module tb_pwm_gen_core;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  pwm_gen_core_if bus ();
  pwm_gen_core dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));
  typedef struct {
    int presc; int period; int d0; int d1; logic [1:0] pol;
    int len; int h0; int h1;
  } vec_t;
  typedef struct {int len; int h0; int h1;} exp_t;
  exp_t sb[$];
  vec_t vt[7];
  int tests = 0;
  int fails = 0;
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input int presc, input int period, input int d0, input int d1, input logic [1:0] pol);
    bus.prescale = 8'(presc);
    bus.period   = 32'(period);
    bus.duty     = {32'(d1), 32'(d0)};
    bus.polarity = pol;
  endtask
  task automatic measure(input int len, output int h0, output int h1, output int pe_at);
    int pe_n;
    h0 = 0; h1 = 0; pe_at = -1; pe_n = 0;
    for (int k = 1; k <= len; k++) begin
      tick;
      h0 += int'(bus.pwm_out[0]);
      h1 += int'(bus.pwm_out[1]);
      if (bus.period_end) begin
        pe_n++;
        pe_at = k;
      end
    end
    if (pe_n != 1) pe_at = -1;
  endtask
  task automatic wait_counter(input int v);
    int n;
    n = 0;
    while (bus.counter != 32'(v) && n < 100) begin
      tick;
      n++;
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int n, h0, h1, pe_at, bad;
    exp_t e;
    vt[0] = '{0, 9, 3, 0,  2'b00, 10, 3, 0};
    vt[1] = '{0, 9, 3, 10, 2'b00, 10, 3, 10};
    vt[2] = '{0, 9, 3, 3,  2'b10, 10, 3, 7};
    vt[3] = '{3, 9, 3, 0,  2'b00, 40, 12, 0};
    vt[4] = '{0, 0, 1, 0,  2'b00, 1, 1, 0};
    vt[5] = '{0, 9, 0, 9,  2'b01, 10, 10, 9};
    vt[6] = '{1, 4, 2, 5,  2'b00, 10, 4, 10};
    bus.enable = 1'b0;
    bus.update_req = 1'b0;
    drive(0, 9, 3, 0, 2'b00);
    tick;
    tick;
    chk("rst_counter", bus.counter, 0);
    chk("rst_pwm", bus.pwm_out, 0);
    chk("rst_ack", bus.update_ack, 0);
    chk("rst_pe", bus.period_end, 0);
    ARESET = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].presc, vt[i].period, vt[i].d0, vt[i].d1, vt[i].pol);
      bus.enable = 1'b1;
      bus.update_req = 1'b1;
      sb.push_back('{vt[i].len, vt[i].h0, vt[i].h1});
      tick;
      bus.update_req = 1'b0;
      n = 0;
      while (!bus.update_ack && n < 200) begin
        tick;
        n++;
      end
      chk($sformatf("row%0d_ack", i), bus.update_ack, 1);
      measure(vt[i].len, h0, h1, pe_at);
      e = sb.pop_front();
      chk($sformatf("row%0d_high0", i), h0, e.h0);
      chk($sformatf("row%0d_high1", i), h1, e.h1);
      chk($sformatf("row%0d_period_end", i), pe_at, e.len);
    end
    drive(0, 9, 3, 0, 2'b00);
    bus.update_req = 1'b1;
    tick;
    bus.update_req = 1'b0;
    n = 0;
    while (!bus.update_ack && n < 50) begin
      tick;
      n++;
    end
    wait_counter(4);
    chk("upd_sync", bus.counter, 4);
    bus.duty[31:0] = 32'd7;
    bus.update_req = 1'b1;
    tick;
    bus.update_req = 1'b0;
    n = 1;
    bad = 0;
    while (!bus.update_ack && n < 50) begin
      bad += int'(bus.pwm_out[0] | bus.period_end);
      tick;
      n++;
    end
    chk("upd_ack_delay", n, 6);
    chk("upd_ack_with_pe", bus.period_end, 1);
    chk("upd_old_period_low", bad, 0);
    measure(10, h0, h1, pe_at);
    chk("upd_new_high0", h0, 7);
    chk("upd_new_pe", pe_at, 10);
    wait_counter(5);
    chk("dis_sync", bus.counter, 5);
    bus.enable = 1'b0;
    tick;
    chk("dis_counter", bus.counter, 0);
    chk("dis_pwm", bus.pwm_out, 0);
    chk("dis_pe", bus.period_end, 0);
    tick;
    tick;
    chk("dis_hold", bus.counter, 0);
    bus.duty[31:0] = 32'd5;
    bus.enable = 1'b1;
    tick;
    chk("reen_no_ack", bus.update_ack, 0);
    measure(10, h0, h1, pe_at);
    chk("reen_high0", h0, 5);
    chk("reen_pe", pe_at, 10);
    wait_counter(4);
    bus.update_req = 1'b1;
    tick;
    bus.update_req = 1'b0;
    chk("rstmid_pre", bus.counter, 5);
    ARESET = 1'b1;
    tick;
    ARESET = 1'b0;
    chk("rstmid_counter", bus.counter, 0);
    chk("rstmid_pwm", bus.pwm_out, 0);
    chk("rstmid_ack", bus.update_ack, 0);
    chk("rstmid_pe", bus.period_end, 0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      bad += int'(bus.update_ack);
    end
    chk("rstmid_no_ack", bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
